// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the ARMv4 shifter sequencer: shift types, FSM states,
// override selects and the single shifter-operand decode function.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OVR_NONE,
    OVR_PASS,
    OVR_ZERO,
    OVR_SIGN,
    OVR_RRX
  } ovr_sel_t;

  typedef struct packed {
    logic [1:0]  sh_type;
    logic [4:0]  sh_amt;
    logic        sh_cin;
    ovr_sel_t    sel;
    logic [31:0] ovr_val;
    logic        ovr_c;
  } dec_t;

  function automatic logic [31:0] ovr_value(input ovr_sel_t sel, input logic [31:0] op,
                                            input logic cin);
    logic [31:0] v;
    v = '0;
    case (sel)
      OVR_PASS: v = op;
      OVR_SIGN: v = {32{op[31]}};
      OVR_RRX:  v = {cin, op[31:1]};
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Anything the 5-bit shifter cannot express is resolved here into an override.
  function automatic dec_t decode(input logic [1:0] t, input logic imm, input logic [31:0] op,
                                  input logic [7:0] a, input logic cin);
    dec_t d;
    d.sh_type = t;
    d.sh_amt  = a[4:0];
    d.sh_cin  = cin;
    d.sel     = OVR_NONE;
    d.ovr_c   = cin;
    d.ovr_val = '0;
    if (imm) begin
      if (a[4:0] == 5'd0) begin
        case (t)
          SH_LSL: begin d.sel = OVR_PASS; d.ovr_c = cin;    end
          SH_LSR: begin d.sel = OVR_ZERO; d.ovr_c = op[31]; end
          SH_ASR: begin d.sel = OVR_SIGN; d.ovr_c = op[31]; end
          default: begin d.sel = OVR_RRX; d.ovr_c = op[0];  end
        endcase
      end
    end else if (a == 8'd0) begin
      d.sel   = OVR_PASS;
      d.ovr_c = cin;
    end else begin
      case (t)
        SH_LSL: begin
          if (a == 8'd32) begin
            d.sel = OVR_ZERO; d.ovr_c = op[0];
          end else if (a > 8'd32) begin
            d.sel = OVR_ZERO; d.ovr_c = 1'b0;
          end
        end
        SH_LSR: begin
          if (a == 8'd32) begin
            d.sel = OVR_ZERO; d.ovr_c = op[31];
          end else if (a > 8'd32) begin
            d.sel = OVR_ZERO; d.ovr_c = 1'b0;
          end
        end
        SH_ASR: begin
          if (a >= 8'd32) begin
            d.sel = OVR_SIGN; d.ovr_c = op[31];
          end
        end
        default: begin
          if (a[4:0] == 5'd0) begin
            d.sel = OVR_PASS; d.ovr_c = op[31];
          end
        end
      endcase
    end
    d.ovr_val = ovr_value(d.sel, op, cin);
    return d;
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/response bundle between the execute stage and the shifter sequencer.
interface shift_ctrl_if #(
  parameter int AMT_W = 8
) ();

  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_type;
  logic             i_imm;
  logic [31:0]      i_op;
  logic [AMT_W-1:0] i_amount;
  logic             i_carry;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic             o_carry;

  modport slave (
    input  i_valid, i_type, i_imm, i_op, i_amount, i_carry, i_ready,
    output o_ready, o_valid, o_result, o_carry
  );

  modport master (
    output i_valid, i_type, i_imm, i_op, i_amount, i_carry, i_ready,
    input  o_ready, o_valid, o_result, o_carry
  );

endinterface

// File: rtl/shift_ctrl_shift.sv
// Combinational 32-bit barrel shifter for amounts 0..31; amount 0 passes the
// operand and carry through unchanged.
module shift
  import shift_pkg::*;
(
  input  logic [1:0]  i_type,
  input  logic [4:0]  i_amt,
  input  logic [31:0] i_op,
  input  logic        i_carry,
  output logic [31:0] o_result,
  output logic        o_carry
);

  logic [32:0] ext;

  always_comb begin
    ext      = '0;
    o_result = i_op;
    o_carry  = i_carry;
    if (i_amt != 5'd0) begin
      case (i_type)
        SH_LSL: begin
          ext      = {1'b0, i_op} << i_amt;
          o_result = ext[31:0];
          o_carry  = ext[32];
        end
        SH_LSR: begin
          ext      = {i_op, 1'b0} >> i_amt;
          o_result = ext[32:1];
          o_carry  = ext[0];
        end
        SH_ASR: begin
          ext      = $signed({i_op, 1'b0}) >>> i_amt;
          o_result = ext[32:1];
          o_carry  = ext[0];
        end
        default: begin
          o_result = (i_op >> i_amt) | (i_op << (6'd32 - {1'b0, i_amt}));
          o_carry  = o_result[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// ARMv4 shifter-operand sequencer: captures a request, decodes the special
// cases, drives the barrel shifter and holds the result behind valid/ready.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int PIPE_DECODE = 1,
  parameter int AMT_W       = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  shift_ctrl_if.slave  bus
);

  state_t      state_q, state_d;
  logic        accept;

  logic [1:0]  type_q;
  logic        imm_q;
  logic [31:0] op_q;
  logic [7:0]  amt_q;
  logic        carry_q;

  dec_t        dec_comb, dec_q, dec_use;
  logic [31:0] sh_res;
  logic        sh_c;
  logic [31:0] result_q;
  logic        carry_out_q;

  assign accept   = (state_q == IDLE) && bus.i_valid && !i_flush;
  assign dec_comb = decode(type_q, imm_q, op_q, amt_q, carry_q);
  assign dec_use  = (PIPE_DECODE != 0) ? dec_q : dec_comb;

  shift u_shift (
    .i_type   (dec_use.sh_type),
    .i_amt    (dec_use.sh_amt),
    .i_op     (op_q),
    .i_carry  (dec_use.sh_cin),
    .o_result (sh_res),
    .o_carry  (sh_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (PIPE_DECODE != 0) ? DEC : EXEC;
      DEC:  state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A flush suppresses the result load so the outputs keep their last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      type_q      <= '0;
      imm_q       <= 1'b0;
      op_q        <= '0;
      amt_q       <= '0;
      carry_q     <= 1'b0;
      dec_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      if (accept) begin
        type_q  <= bus.i_type;
        imm_q   <= bus.i_imm;
        op_q    <= bus.i_op;
        amt_q   <= bus.i_amount[7:0];
        carry_q <= bus.i_carry;
      end
      if ((state_q == DEC) && !i_flush) dec_q <= dec_comb;
      if ((state_q == EXEC) && !i_flush) begin
        result_q    <= (dec_use.sel == OVR_NONE) ? sh_res : dec_use.ovr_val;
        carry_out_q <= (dec_use.sel == OVR_NONE) ? sh_c   : dec_use.ovr_c;
      end
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = result_q;
  assign bus.o_carry  = carry_out_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl (registered decode): decode cases, latency,
// backpressure, flush and asynchronous reset.
module tb_shift_ctrl;
  import shift_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  shift_ctrl_if #(.AMT_W(8)) bus ();

  shift_ctrl #(.PIPE_DECODE(1), .AMT_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic [1:0] t, input logic imm,
                     input logic [31:0] op, input logic [7:0] a, input logic c,
                     input logic [31:0] er, input logic ec, input int hold);
    int lat;
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_type   = t;
    bus.i_imm    = imm;
    bus.i_op     = op;
    bus.i_amount = a;
    bus.i_carry  = c;
    chk1({tag, ".ready_idle"}, bus.o_ready, 1'b1);
    @(posedge clk); #1;
    // scramble the request fields: they must have been captured at accept
    bus.i_valid  = 1'b0;
    bus.i_type   = ~t;
    bus.i_imm    = ~imm;
    bus.i_op     = ~op;
    bus.i_amount = ~a;
    bus.i_carry  = ~c;
    lat = 1;
    chk1({tag, ".ready_busy"}, bus.o_ready, 1'b0);
    while (!bus.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk32({tag, ".latency"}, 32'(lat), 32'd3);
    chk32({tag, ".result"}, bus.o_result, er);
    chk1({tag, ".carry"}, bus.o_carry, ec);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk1({tag, ".hold_valid"}, bus.o_valid, 1'b1);
      chk32({tag, ".hold_result"}, bus.o_result, er);
      chk1({tag, ".hold_carry"}, bus.o_carry, ec);
      chk1({tag, ".hold_ready"}, bus.o_ready, 1'b0);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk1({tag, ".valid_drop"}, bus.o_valid, 1'b0);
    chk1({tag, ".ready_back"}, bus.o_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_type   = 2'd0;
    bus.i_imm    = 1'b0;
    bus.i_op     = '0;
    bus.i_amount = '0;
    bus.i_carry  = 1'b0;
    bus.i_ready  = 1'b0;

    #1;
    chk1 ("reset.ready",  bus.o_ready,  1'b1);
    chk1 ("reset.valid",  bus.o_valid,  1'b0);
    chk32("reset.result", bus.o_result, 32'h0);
    chk1 ("reset.carry",  bus.o_carry,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //  tag          type    imm   op            amt     C     result        C     hold
    req("lsl_r4",    SH_LSL, 1'b0, 32'h8000_000F, 8'd4,   1'b0, 32'h0000_00F0, 1'b0, 5);
    req("lsr_r32",   SH_LSR, 1'b0, 32'h8000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 0);
    req("lsr_r33",   SH_LSR, 1'b0, 32'h8000_0001, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 0);
    req("asr_r200",  SH_ASR, 1'b0, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);
    req("ror_i0",    SH_ROR, 1'b1, 32'h0000_0003, 8'd0,   1'b1, 32'h8000_0001, 1'b1, 0);
    req("lsr_i0",    SH_LSR, 1'b1, 32'h7FFF_FFFF, 8'd0,   1'b1, 32'h0000_0000, 1'b0, 0);
    req("ror_r64",   SH_ROR, 1'b0, 32'h8000_0001, 8'd64,  1'b0, 32'h8000_0001, 1'b1, 0);
    req("ror_r0",    SH_ROR, 1'b0, 32'h1234_5678, 8'd0,   1'b0, 32'h1234_5678, 1'b0, 0);
    req("lsl_i0",    SH_LSL, 1'b1, 32'hA5A5_A5A5, 8'd0,   1'b1, 32'hA5A5_A5A5, 1'b1, 0);
    req("asr_i0",    SH_ASR, 1'b1, 32'h8000_0000, 8'd0,   1'b0, 32'hFFFF_FFFF, 1'b1, 0);
    req("ror_i4",    SH_ROR, 1'b1, 32'h0000_008F, 8'd4,   1'b0, 32'hF000_0008, 1'b1, 0);
    req("ror_r36",   SH_ROR, 1'b0, 32'h0000_008F, 8'd36,  1'b0, 32'hF000_0008, 1'b1, 0);
    req("lsl_r32",   SH_LSL, 1'b0, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 0);
    req("lsl_r33",   SH_LSL, 1'b0, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 0);
    req("asr_r4",    SH_ASR, 1'b0, 32'h8000_0018, 8'd4,   1'b0, 32'hF800_0001, 1'b1, 0);
    req("lsr_r31",   SH_LSR, 1'b0, 32'h8000_0000, 8'd31,  1'b1, 32'h0000_0001, 1'b0, 0);
    req("lsl_i31",   SH_LSL, 1'b1, 32'h0000_0003, 8'd31,  1'b0, 32'h8000_0000, 1'b1, 0);
    req("lsr_i_hi",  SH_LSR, 1'b1, 32'h0000_00F0, 8'hE4,  1'b1, 32'h0000_000F, 1'b0, 0);
    req("lsr_i1",    SH_LSR, 1'b1, 32'h0000_0003, 8'd1,   1'b0, 32'h0000_0001, 1'b1, 0);

    // flush while in DEC: back to IDLE, outputs keep the previous result
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_type = SH_LSL; bus.i_imm = 1'b0;
    bus.i_op = 32'h0000_000F; bus.i_amount = 8'd4; bus.i_carry = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk1("flush.ready_dec", bus.o_ready, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk1 ("flush.valid",  bus.o_valid,  1'b0);
    chk1 ("flush.ready",  bus.o_ready,  1'b1);
    chk32("flush.result", bus.o_result, 32'h0000_0001);
    chk1 ("flush.carry",  bus.o_carry,  1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk1("flush.no_valid", bus.o_valid, 1'b0);
    end

    // flush together with valid in IDLE: request must be refused
    @(negedge clk);
    bus.i_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; flush = 1'b0;
    chk1("flush_idle.ready", bus.o_ready, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk1("flush_idle.no_valid", bus.o_valid, 1'b0);
    end

    // asynchronous reset while in EXEC
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_type = SH_ASR; bus.i_imm = 1'b0;
    bus.i_op = 32'h8000_0000; bus.i_amount = 8'd200; bus.i_carry = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    chk1("rst_exec.ready_busy", bus.o_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1 ("rst_exec.ready",  bus.o_ready,  1'b1);
    chk1 ("rst_exec.valid",  bus.o_valid,  1'b0);
    chk32("rst_exec.result", bus.o_result, 32'h0);
    chk1 ("rst_exec.carry",  bus.o_carry,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk1 ("rst_exec.no_valid",  bus.o_valid,  1'b0);
      chk32("rst_exec.no_stale",  bus.o_result, 32'h0);
    end

    req("post_rst",  SH_LSL, 1'b0, 32'h8000_000F, 8'd4,   1'b0, 32'h0000_00F0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
